// File: rtl/morse_key_timer.sv
// Telegraph-key front end: synchronizes and debounces the raw key, then times
// presses and releases into Dot/Dash/EndSeq/Space strobes for the Morse encoder.
module morse_key_timer #(
    parameter int DEBOUNCE   = 4,
    parameter int DOT_MAX    = 20,
    parameter int LETTER_GAP = 60,
    parameter int WORD_GAP   = 140,
    parameter int MAX_SYM    = 5,
    parameter int CNT_W      = 16
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Key,
    output logic       Dot,
    output logic       Dash,
    output logic       EndSeq,
    output logic       Space,
    output logic [2:0] SymCount,
    output logic       KeyDb
);

    // state    | meaning
    // WAIT_REL | after reset; wait until the key path is settled released
    // IDLE     | no letter open
    // PRESS    | key down, press counter running
    // GAP      | key up inside a letter, gap counter running
    // WORDWAIT | letter closed, still counting toward the word gap
    typedef enum logic [2:0] {WAIT_REL, IDLE, PRESS, GAP, WORDWAIT} state_t;

    localparam int DB_W = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DOT_LIM  = CNT_W'(DOT_MAX);
    localparam logic [CNT_W-1:0] LG_LIM   = CNT_W'(LETTER_GAP);
    localparam logic [CNT_W-1:0] WG_LIM   = CNT_W'(WORD_GAP);
    localparam logic [CNT_W-1:0] SETTLE   = CNT_W'(DEBOUNCE + 2);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE - 1);
    localparam logic [2:0]       SYM_LIM  = 3'(MAX_SYM);

    state_t            state;
    logic              key_s1, key_s2;
    logic [DB_W-1:0]   db_cnt;
    logic [CNT_W-1:0]  press_cnt, gap_cnt;
    logic [CNT_W-1:0]  press_nxt, gap_nxt;
    logic              quiet;

    assign press_nxt = (press_cnt == CNT_MAX) ? press_cnt : press_cnt + CNT_ONE;
    assign gap_nxt   = (gap_cnt == CNT_MAX) ? gap_cnt : gap_cnt + CNT_ONE;
    // A key held through reset is still in the synchronizer when reset drops,
    // so release is only trusted once the whole input path reads low.
    assign quiet     = !key_s1 && !key_s2 && !KeyDb;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            key_s1 <= 1'b0;
            key_s2 <= 1'b0;
            db_cnt <= '0;
            KeyDb  <= 1'b0;
        end else begin
            key_s1 <= Key;
            key_s2 <= key_s1;
            if (key_s2 != KeyDb) begin
                if (db_cnt == DB_LAST) begin
                    KeyDb  <= key_s2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= WAIT_REL;
            press_cnt <= '0;
            gap_cnt   <= '0;
            SymCount  <= 3'd0;
            Dot       <= 1'b0;
            Dash      <= 1'b0;
            EndSeq    <= 1'b0;
            Space     <= 1'b0;
        end else begin
            Dot    <= 1'b0;
            Dash   <= 1'b0;
            EndSeq <= 1'b0;
            Space  <= 1'b0;
            case (state)
                WAIT_REL: begin
                    if (quiet) begin
                        gap_cnt <= gap_nxt;
                        if (gap_nxt >= SETTLE) begin
                            gap_cnt <= '0;
                            state   <= IDLE;
                        end
                    end else begin
                        gap_cnt <= '0;
                    end
                end
                IDLE: begin
                    if (KeyDb) begin
                        press_cnt <= CNT_ONE;
                        state     <= PRESS;
                    end
                end
                PRESS: begin
                    if (KeyDb) begin
                        press_cnt <= press_nxt;
                    end else begin
                        if (press_cnt <= DOT_LIM) Dot <= 1'b1;
                        else                      Dash <= 1'b1;
                        SymCount <= SymCount + 3'd1;
                        gap_cnt  <= CNT_ONE;
                        state    <= GAP;
                    end
                end
                GAP: begin
                    if (KeyDb) begin
                        press_cnt <= CNT_ONE;
                        state     <= PRESS;
                        // A full letter is closed by the next press itself.
                        if (SymCount == SYM_LIM) begin
                            EndSeq   <= 1'b1;
                            SymCount <= 3'd0;
                        end
                    end else begin
                        gap_cnt <= gap_nxt;
                        if (gap_nxt >= LG_LIM) begin
                            EndSeq   <= 1'b1;
                            SymCount <= 3'd0;
                            state    <= WORDWAIT;
                        end
                    end
                end
                WORDWAIT: begin
                    if (KeyDb) begin
                        press_cnt <= CNT_ONE;
                        state     <= PRESS;
                    end else begin
                        gap_cnt <= gap_nxt;
                        if (gap_nxt >= WG_LIM) begin
                            Space <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= WAIT_REL;
            endcase
        end
    end

endmodule

// File: tb/tb_morse_key_timer.sv
// Bench for morse_key_timer: directed and random key patterns compared each
// cycle against a run-length model of the debounced key and letter timing.
module tb_morse_key_timer;

    localparam int DEB = 2, DMAX = 3, LG = 6, WG = 14, MS = 5, CW = 8;
    localparam int LAT = 2 + DEB;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Key = 1'b0;
    logic       Dot, Dash, EndSeq, Space, KeyDb;
    logic [2:0] SymCount;

    int n_checks = 0;
    int n_fail   = 0;
    int key_q[$];

    morse_key_timer #(
        .DEBOUNCE(DEB), .DOT_MAX(DMAX), .LETTER_GAP(LG), .WORD_GAP(WG),
        .MAX_SYM(MS), .CNT_W(CW)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Key(Key),
        .Dot(Dot), .Dash(Dash), .EndSeq(EndSeq), .Space(Space),
        .SymCount(SymCount), .KeyDb(KeyDb)
    );

    always #5 Clk = ~Clk;

    function automatic logic [7:0] obs();
        return {KeyDb, Space, EndSeq, Dash, Dot, SymCount};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic add_seg(input int lvl, input int len);
        repeat (len) key_q.push_back(lvl);
    endtask

    task automatic drive_q();
        foreach (key_q[i]) begin
            Key = 1'(key_q[i]);
            step();
        end
        key_q.delete();
    endtask

    // Strobes and SymCount must stay quiet; KeyDb is free to move.
    task automatic idle_check(input string name, input int n, input logic lvl);
        for (int c = 0; c < n; c++) begin
            check($sformatf("%s@%0d", name, c), {24'd0, obs() & 8'h7F}, 32'd0);
            Key = lvl;
            step();
        end
    endtask

    // Expected outputs come from run lengths of the filtered, delayed key:
    // symbol one cycle after a fall, EndSeq/Space LG/WG cycles after a fall if
    // the gap lasts that long, forced EndSeq one cycle after a rise on a full letter.
    task automatic run_scenario(input string name);
        int nk, n, sym, rise, last_fall, g, cur, i, j;
        int kf[];
        int kd[];
        int ev[];
        int symset[];
        logic [7:0] e;
        repeat (WG + 12) key_q.push_back(0);
        nk = key_q.size();
        n  = nk + LAT;
        kf = new[nk];
        foreach (key_q[k]) kf[k] = key_q[k];
        i = 0;
        while (i < nk) begin
            j = i;
            while (j < nk && key_q[j] == key_q[i]) j++;
            if (j - i < DEB && i > 0)
                for (int k = i; k < j; k++) kf[k] = kf[i-1];
            i = j;
        end
        kd = new[n];
        ev = new[n];
        symset = new[n];
        for (int c = 0; c < n; c++) begin
            kd[c] = (c >= LAT) ? kf[c-LAT] : 0;
            ev[c] = 0;
            symset[c] = -1;
        end
        sym = 0; rise = 0; last_fall = -1;
        for (int c = 1; c < n; c++) begin
            if (kd[c] == 1 && kd[c-1] == 0) begin
                rise = c;
                if (last_fall >= 0 && sym == MS) begin
                    ev[c+1] = 3; symset[c+1] = 0; sym = 0;
                end
            end else if (kd[c] == 0 && kd[c-1] == 1) begin
                last_fall = c;
                sym++;
                ev[c+1] = (c - rise <= DMAX) ? 1 : 2;
                symset[c+1] = sym;
                g = n - c;
                for (int k = c + 1; k < n; k++)
                    if (kd[k] == 1) begin g = k - c; break; end
                if (g >= LG) begin ev[c+LG] = 3; symset[c+LG] = 0; sym = 0; end
                if (g >= WG) ev[c+WG] = 4;
            end
        end
        cur = 0;
        for (int c = 0; c < n; c++) begin
            if (symset[c] >= 0) cur = symset[c];
            e = {1'(kd[c]), ev[c] == 4, ev[c] == 3, ev[c] == 2, ev[c] == 1, 3'(cur)};
            check($sformatf("%s@%0d", name, c), {24'd0, obs()}, {24'd0, e});
            Key = (c < nk) ? 1'(key_q[c]) : 1'b0;
            step();
        end
        key_q.delete();
    endtask

    initial begin
        Reset = 1'b1;
        Key = 1'b0;
        step();
        step();
        check("reset", {24'd0, obs()}, 32'd0);
        step();
        Reset = 1'b0;

        add_seg(0, 30);
        run_scenario("idle");

        add_seg(1, 2); add_seg(0, 2); add_seg(1, 6); add_seg(0, 20);
        run_scenario("letter_a");

        add_seg(1, 3); add_seg(0, 20);
        add_seg(1, 4); add_seg(0, 20);
        add_seg(1, 257); add_seg(0, 20);
        add_seg(1, 5000); add_seg(0, 20);
        run_scenario("dot_dash");

        add_seg(1, 2); add_seg(0, 5); add_seg(1, 2); add_seg(0, 20);
        add_seg(1, 2); add_seg(0, 6); add_seg(1, 2); add_seg(0, 20);
        run_scenario("gap_thr");

        repeat (6) begin add_seg(1, 2); add_seg(0, 2); end
        add_seg(0, 20);
        run_scenario("sym_limit");

        repeat (12) begin add_seg(0, 9); add_seg(1, 1); end
        run_scenario("glitch");

        Key = 1'b1;
        repeat (6) step();
        Reset = 1'b1;
        #1;
        check("rst_press_a", {24'd0, obs()}, 32'd0);
        step();
        check("rst_press_b", {24'd0, obs()}, 32'd0);
        Reset = 1'b0;
        idle_check("held", 10, 1'b1);
        idle_check("released", 30, 1'b0);
        add_seg(1, 2);
        run_scenario("repress");

        add_seg(1, 2); add_seg(0, 2); add_seg(1, 2); add_seg(0, 2);
        add_seg(1, 2); add_seg(0, 7);
        drive_q();
        check("sym3", {29'd0, SymCount}, 32'd3);
        Reset = 1'b1;
        step();
        check("rst_gap", {24'd0, obs()}, 32'd0);
        Reset = 1'b0;
        idle_check("after_gap_rst", 30, 1'b0);

        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 12; k++) begin
                if ($urandom_range(0, 9) == 0) add_seg(1, $urandom_range(20, 40));
                else                           add_seg(1, $urandom_range(2, 6));
                if ($urandom_range(0, 1) == 0) add_seg(0, $urandom_range(2, 5));
                else                           add_seg(0, $urandom_range(2, WG + 4));
            end
            run_scenario($sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
